rstack: RTL and testbench
=========================

// Module: rstack
// PURPOSE
//  Return stack for the Forth core. Feeds the return-address operand (rstack_top) of the next-IP mux.
//  Takes pushes from call / >R and pops from return / R>.
//  Top of stack is held in a dedicated register, so rstack_top is a register output with no read latency.
//  Lower entries sit in a DEPTH-1 register array. Sticky overflow/underflow flags report misuse to the debug path.
// PARAMETERS
//  iaddr_width  10  width of each stack entry (matches instruction address width)
//  DEPTH        16  total entries including top register; >=2
//  CNT_W        5   width of count; must satisfy 2**CNT_W > DEPTH
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            synchronous, active-high
//  push         in   1            push push_data this cycle
//  pop          in   1            pop top entry this cycle
//  push_data    in   iaddr_width  value to push (return address or TOS)
//  err_clr      in   1            clear sticky error flags
//  rstack_top   out  iaddr_width  current top entry (registered)
//  count        out  CNT_W        number of valid entries, 0..DEPTH
//  empty        out  1            count==0
//  full         out  1            count==DEPTH
//  overflow     out  1            sticky: push attempted while full (without pop)
//  underflow    out  1            sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (clk edge with reset=1): count=0, rstack_top=0, empty=1, full=0, overflow=0, underflow=0.
//   Reset overrides every other input. Array contents are don't-care.
//  All updates occur on the rising clk edge. Results are visible the cycle after the operation.
//  empty/full are decoded from the count register (combinational off registers, no extra latency).
//  Storage: top register T; array M[0..DEPTH-2]; M[count-2] is the entry directly below T.
//  push=1, pop=0:
//   - count==0: T<=push_data, count<=1.
//   - 0<count<DEPTH: M[count-1]<=T, T<=push_data, count<=count+1.
//   - count==DEPTH: no state change; overflow<=1.
//  push=0, pop=1:
//   - count>1: T<=M[count-2], count<=count-1.
//   - count==1: T<=0, count<=0.
//   - count==0: no state change; underflow<=1.
//  push=1, pop=1 (replace top, e.g. tail-call):
//   - count>=1: T<=push_data; count unchanged; never sets overflow, even when full.
//   - count==0: acts as push (T<=push_data, count<=1); underflow<=1.
//  push=0, pop=0: hold all state.
//  err_clr=1 clears overflow and underflow.
//   If an error condition occurs in the same cycle, that flag is set (set wins over clear).
//  Array read for pop is combinational from M (distributed-RAM style). No bypass is needed:
//   T is the only location written and read in the same cycle.
//  No wrap-around: count saturates at 0 and DEPTH, and the stack contents are preserved on illegal ops.
// TESTING
//  1. Reset, then push 0x012,0x034,0x056 on consecutive cycles
//     -> rstack_top 0x012,0x034,0x056 one cycle after each push; count=3.
//  2. From 1, pop x3
//     -> rstack_top 0x034, 0x012, 0x000; count 2,1,0; empty=1 after the last pop; underflow stays 0.
//  3. Push DEPTH values 1..16, then push 0x3FF
//     -> full=1, overflow=1, rstack_top stays 16, count=16.
//     Then pop x16 returns 16..1 in order.
//  4. count=2 (top 0x020, below 0x010), push=pop=1 with 0x0AA
//     -> top 0x0AA, count 2. Next pop -> top 0x010.
//  5. Empty stack, pop=1 -> underflow=1, count 0.
//     Then err_clr=1 together with pop=1 on empty -> underflow remains 1.
//     err_clr alone -> underflow 0.
//  6. Assert reset mid-sequence at count=5 with push=1
//     -> next cycle count=0, rstack_top=0, flags 0, push ignored.

Source files
------------

// File: rtl/rstack_if.sv
// Return-stack port bundle: push/pop request side and registered stack status.
interface rstack_if #(
  parameter int iaddr_width = 10,
  parameter int CNT_W       = 5
);
  logic                   push;
  logic                   pop;
  logic [iaddr_width-1:0] push_data;
  logic                   err_clr;
  logic [iaddr_width-1:0] rstack_top;
  logic [CNT_W-1:0]       count;
  logic                   empty;
  logic                   full;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output push, pop, push_data, err_clr,
    input  rstack_top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output rstack_top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/rstack.sv
// Forth return stack: registered top entry plus a DEPTH-1 entry array below it.
// Latency: one cycle from push/pop to rstack_top/count; no backpressure, misuse sets sticky flags.
// Illegal push (full) or pop (empty) leaves contents untouched and latches overflow/underflow.
module rstack #(
  parameter int iaddr_width = 10,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 5
) (
  input logic   clk,
  input logic   reset,
  rstack_if.slave rs
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [iaddr_width-1:0] top_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic                   unf_q;
  logic [iaddr_width-1:0] mem [DEPTH-1];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          mem_we;

  // M[count-1] receives the old top on push; M[count-2] sits directly under it.
  assign wr_idx = AW'(cnt_q - CNT_ONE);
  assign rd_idx = AW'(cnt_q - CNT_W'(2));
  assign mem_we = rs.push && !rs.pop && (cnt_q != '0) && (cnt_q != CNT_FULL) && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= top_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (rs.err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case ({rs.push, rs.pop})
        2'b10: begin
          if (cnt_q == CNT_FULL) begin
            ovf_q <= 1'b1;
          end else begin
            top_q <= rs.push_data;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        2'b01: begin
          if (cnt_q == '0) begin
            unf_q <= 1'b1;
          end else if (cnt_q == CNT_ONE) begin
            top_q <= '0;
            cnt_q <= '0;
          end else begin
            top_q <= mem[rd_idx];
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        2'b11: begin
          // Replace-top; on an empty stack this degenerates to a push but still flags the pop.
          top_q <= rs.push_data;
          if (cnt_q == '0) begin
            cnt_q <= CNT_ONE;
            unf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rs.rstack_top = top_q;
  assign rs.count      = cnt_q;
  assign rs.empty      = (cnt_q == '0);
  assign rs.full       = (cnt_q == CNT_FULL);
  assign rs.overflow   = ovf_q;
  assign rs.underflow  = unf_q;
endmodule

// File: tb/tb_rstack.sv
// Directed bench for rstack: hand-computed expectations checked one cycle after each operation.
module tb_rstack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  rstack_if #(.iaddr_width(10), .CNT_W(5)) rs ();

  rstack #(.iaddr_width(10), .DEPTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input logic p, input logic q, input logic [9:0] d, input logic c);
    rs.push      = p;
    rs.pop       = q;
    rs.push_data = d;
    rs.err_clr   = c;
    @(posedge clk);
    #1;
    rs.push      = 1'b0;
    rs.pop       = 1'b0;
    rs.push_data = '0;
    rs.err_clr   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [9:0] top, input int cnt,
                             input logic ovf, input logic unf);
    check({tag, ".top"}, 32'(rs.rstack_top), 32'(top));
    check({tag, ".count"}, 32'(rs.count), 32'(cnt));
    check({tag, ".empty"}, 32'(rs.empty), 32'(cnt == 0));
    check({tag, ".full"}, 32'(rs.full), 32'(cnt == 16));
    check({tag, ".ovf"}, 32'(rs.overflow), 32'(ovf));
    check({tag, ".unf"}, 32'(rs.underflow), 32'(unf));
  endtask

  initial begin
    rs.push = 1'b0; rs.pop = 1'b0; rs.push_data = '0; rs.err_clr = 1'b0;

    reset = 1'b1;
    step(0, 0, 10'h0, 0);
    reset = 1'b0;
    check_state("reset", 10'h000, 0, 0, 0);

    // Three pushes, then three pops back to empty.
    step(1, 0, 10'h012, 0); check_state("push1", 10'h012, 1, 0, 0);
    step(1, 0, 10'h034, 0); check_state("push2", 10'h034, 2, 0, 0);
    step(1, 0, 10'h056, 0); check_state("push3", 10'h056, 3, 0, 0);
    step(0, 1, 10'h0, 0);   check_state("pop1", 10'h034, 2, 0, 0);
    step(0, 1, 10'h0, 0);   check_state("pop2", 10'h012, 1, 0, 0);
    step(0, 1, 10'h0, 0);   check_state("pop3", 10'h000, 0, 0, 0);

    // Fill to DEPTH, overflow, clear, replace-top while full, then drain.
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 10'(i), 0);
      check("fill.top", 32'(rs.rstack_top), 32'(i));
      check("fill.count", 32'(rs.count), 32'(i));
    end
    check_state("full", 10'd16, 16, 0, 0);
    step(1, 0, 10'h3FF, 0); check_state("ovf", 10'd16, 16, 1, 0);
    step(0, 0, 10'h0, 1);   check_state("ovf_clr", 10'd16, 16, 0, 0);
    step(1, 1, 10'h155, 0); check_state("repl_full", 10'h155, 16, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 10'h0, 0);
      check("drain.top", 32'(rs.rstack_top), 32'(16 - k));
      check("drain.count", 32'(rs.count), 32'(16 - k));
    end
    check_state("drained", 10'h000, 0, 0, 0);

    // Replace-top at count 2.
    step(1, 0, 10'h010, 0);
    step(1, 0, 10'h020, 0); check_state("c2", 10'h020, 2, 0, 0);
    step(1, 1, 10'h0AA, 0); check_state("repl", 10'h0AA, 2, 0, 0);
    step(0, 1, 10'h0, 0);   check_state("repl_pop", 10'h010, 1, 0, 0);
    step(0, 1, 10'h0, 0);   check_state("repl_pop2", 10'h000, 0, 0, 0);

    // Underflow, set-wins-over-clear, then clear.
    step(0, 1, 10'h0, 0);   check_state("unf", 10'h000, 0, 0, 1);
    step(0, 1, 10'h0, 1);   check_state("unf_setwin", 10'h000, 0, 0, 1);
    step(0, 0, 10'h0, 1);   check_state("unf_clr", 10'h000, 0, 0, 0);

    // Replace-top on empty acts as a push and flags underflow.
    step(1, 1, 10'h2C3, 0); check_state("repl_empty", 10'h2C3, 1, 0, 1);
    step(0, 1, 10'h0, 1);   check_state("repl_empty_pop", 10'h000, 0, 0, 0);

    // Reset mid-sequence with a push pending and a sticky flag set.
    step(0, 1, 10'h0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 10'(10'h100 + i), 0);
    check_state("pre_rst", 10'h104, 5, 0, 1);
    reset = 1'b1;
    step(1, 0, 10'h1FF, 0);
    reset = 1'b0;
    check_state("mid_rst", 10'h000, 0, 0, 0);
    step(1, 0, 10'h077, 0); check_state("post_rst", 10'h077, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
